// File: rtl/device_event_scanner_if.sv
// Device level lines into the scanner and the count commands it issues to the monitor.
// The master side belongs to the scanner; the slave side is the environment driving devices.
interface device_event_scanner_if #(
  parameter int unsigned N_DEV = 8
);
  localparam int unsigned CNT_W = 8;

  logic [N_DEV-1:0] dev_active;
  logic             change;
  logic             on_off;
  logic             busy;
  logic [CNT_W-1:0] active_cnt;

  modport master (
    input  dev_active,
    output change,
    output on_off,
    output busy,
    output active_cnt
  );

  modport slave (
    output dev_active,
    input  change,
    input  on_off,
    input  busy,
    input  active_cnt
  );
endinterface

// File: rtl/device_event_scanner.sv
// Converts per-device level changes into one change/on_off command per clock,
// serviced round-robin so simultaneous changes are reported fairly.
module device_event_scanner #(
  parameter int unsigned N_DEV = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  device_event_scanner_if.master bus
);

  localparam int unsigned CNT_W = 8;

  logic [N_DEV-1:0] dev_q;
  logic [N_DEV-1:0] rep;
  logic [N_DEV-1:0] pending;
  logic [N_DEV-1:0] pending_after;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;
  logic             grant_level;

  logic             change_r;
  logic             on_off_r;
  logic             busy_r;
  logic [CNT_W-1:0] active_cnt_r;

  // A device is pending while its sampled level differs from what was last reported.
  assign pending = dev_q ^ rep;

  // Round-robin search: first pending device at or after ptr, wrapping once.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      idx = (k + 32'(ptr)) % N_DEV;
      if (!grant_vld && pending[PTR_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  assign grant_level = dev_q[grant_idx];

  // Pending set once this cycle's grant has been reported; drives busy.
  always_comb begin
    pending_after = pending;
    if (grant_vld) begin
      pending_after[grant_idx] = 1'b0;
    end
  end

  always_comb begin
    if (32'(grant_idx) == N_DEV - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_q        <= '0;
      rep          <= '0;
      ptr          <= '0;
      change_r     <= 1'b0;
      on_off_r     <= 1'b0;
      busy_r       <= 1'b0;
      active_cnt_r <= '0;
    end else begin
      dev_q  <= bus.dev_active;
      busy_r <= |pending_after;
      if (grant_vld) begin
        rep[grant_idx] <= grant_level;
        ptr            <= ptr_nxt;
        change_r       <= 1'b1;
        on_off_r       <= grant_level;
        // Bounded 0..N_DEV by construction: an off command implies a reported on.
        if (grant_level) begin
          active_cnt_r <= active_cnt_r + CNT_W'(1);
        end else begin
          active_cnt_r <= active_cnt_r - CNT_W'(1);
        end
      end else begin
        change_r <= 1'b0;
        on_off_r <= 1'b0;
      end
    end
  end

  assign bus.change     = change_r;
  assign bus.on_off     = on_off_r;
  assign bus.busy       = busy_r;
  assign bus.active_cnt = active_cnt_r;

endmodule

// File: tb/tb_device_event_scanner.sv
// Scoreboard bench: directed device patterns push expected commands; a monitor
// pops them on every change pulse and tracks a downstream monitor counter.
module tb_device_event_scanner;
  localparam int unsigned N_DEV = 8;
  localparam int unsigned PTR_W = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  device_event_scanner_if #(.N_DEV(N_DEV)) bus ();

  device_event_scanner #(.N_DEV(N_DEV), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       on_off;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mon_cnt  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic push(input logic o, input int c);
    exp_t e;
    e.on_off = o;
    e.cnt    = 8'(c);
    exp_q.push_back(e);
  endtask

  // Downstream monitor counter, reset together with the scanner.
  always @(posedge clk) begin
    if (rst) mon_cnt <= 0;
    else if (bus.change) mon_cnt <= mon_cnt + (bus.on_off ? 1 : -1);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    int   exp_cnt;
    exp_t e;
    if (bus.change) begin
      check("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_on_off", int'(bus.on_off), int'(e.on_off));
        check("pulse_cnt", int'(bus.active_cnt), int'(e.cnt));
      end
      exp_cnt = mon_cnt + (bus.on_off ? 1 : -1);
    end else begin
      check("idle_on_off", int'(bus.on_off), 0);
      exp_cnt = mon_cnt;
    end
    check("monitor_vs_active_cnt", int'(bus.active_cnt), exp_cnt);
  end

  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    #1 bus.dev_active = v;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.dev_active = '0;
    repeat (n) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    repeat (3) @(negedge clk);
    while ((bus.busy || bus.change) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check(name, int'(bus.busy || bus.change), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    bus.dev_active = '0;

    // Test 1: reset state held, then idle with no devices.
    repeat (2) @(negedge clk);
    check("t1_rst_change", int'(bus.change), 0);
    check("t1_rst_busy", int'(bus.busy), 0);
    check("t1_rst_cnt", int'(bus.active_cnt), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_idle_change", int'(bus.change), 0);
      check("t1_idle_busy", int'(bus.busy), 0);
    end

    // Test 2: single device on, pulse two edges later.
    drive(8'h01);
    push(1'b1, 1);
    @(negedge clk);
    check("t2_lat_e0", int'(bus.change), 0);
    @(negedge clk);
    check("t2_lat_e1", int'(bus.change), 1);
    wait_idle("t2_idle");
    check("t2_cnt", int'(bus.active_cnt), 1);
    check("t2_busy", int'(bus.busy), 0);

    // Test 3: all devices on, eight back-to-back up pulses.
    do_reset(2);
    drive(8'hFF);
    for (int i = 1; i <= 8; i++) push(1'b1, i);
    @(negedge clk);
    check("t3_first_gap", int'(bus.change), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_burst", int'(bus.change), 1);
    end
    @(negedge clk);
    check("t3_end", int'(bus.change), 0);
    check("t3_cnt", int'(bus.active_cnt), 8);
    check("t3_busy", int'(bus.busy), 0);

    // Test 5: drop dev6 and dev1 together (ptr wrapped to 0).
    drive(8'hBD);
    push(1'b0, 7);
    push(1'b0, 6);
    wait_idle("t5_idle");
    check("t5_cnt", int'(bus.active_cnt), 6);

    // Round-robin order: ptr=7 so dev7 off is served before dev1 on.
    drive(8'h3F);
    push(1'b0, 5);
    push(1'b1, 6);
    wait_idle("t7_idle");
    check("t7_cnt", int'(bus.active_cnt), 6);

    // Test 4: dev7 glitches on for one sample and is never reported.
    do_reset(2);
    drive(8'hFF);
    drive(8'h7F);
    for (int i = 1; i <= 7; i++) push(1'b1, i);
    wait_idle("t4_idle");
    check("t4_cnt", int'(bus.active_cnt), 7);
    check("t4_busy", int'(bus.busy), 0);

    // Test 6: reset after the third pulse, then full re-report.
    do_reset(2);
    drive(8'hFF);
    for (int i = 1; i <= 3; i++) push(1'b1, i);
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      @(negedge clk);
      if (bus.change) seen++;
    end
    check("t6_three_pulses", seen, 3);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_change", int'(bus.change), 0);
    check("t6_rst_cnt", int'(bus.active_cnt), 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    #1 rst = 1'b0;
    for (int i = 1; i <= 8; i++) push(1'b1, i);
    wait_idle("t6_idle");
    check("t6_cnt", int'(bus.active_cnt), 8);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
